tm_mem_latency_responder: RTL
=============================

Name: tm_mem_latency_responder

Overview:
- Responder end of the L1-to-memory-system timing request interface (tm_mem_request_t).
- Accepts one miss request per thread token and models L2 hit/miss by looking up a direct-mapped L2 tag table.
- Charges a configurable per-thread target-cycle latency, plus a writeback penalty when the request carries a writeback.
- Drives same-cycle stay_stalled for the tid presented, until that thread's latency has been consumed by its own tokens.

Parameters:
- NTHREADS, 2**(NTHREADIDMSB+1): number of thread contexts; one countdown per thread.
- LAT_W, 8: width of latency config fields and of each per-thread countdown.
- L2_SETS, 256: number of L2 tag table entries; must be a power of 2.
- LINE_BITS, 6: address bits below the L2 line index.

Ports:
- gclk  input  iu_clk_type  clock bundle; all state updates on posedge gclk.clk.
- rst  input  1  asynchronous, active-high reset.
- run_reg  input  1  timing model enable; when 0, no state changes.
- req  input  tm_mem_request_t  token_valid, tid, partitionid, request_valid, request_addr, writeback_valid, writeback_addr.
- l2_hit_lat  input  LAT_W  target cycles charged on an L2 hit.
- dram_lat  input  LAT_W  target cycles charged on an L2 miss.
- wb_penalty  input  LAT_W  extra cycles added when req.writeback_valid=1.
- stay_stalled  output  1  combinational; stall indication for req.tid in the current cycle.
- resp_ctrs  output  tm_mem_resp_ctrs_t  one-cycle pulses: l2hit, l2miss, writeback, proto_err.
- busy_vec  output  NTHREADS  registered; bit t=1 while cnt[t]!=0.

Behaviour:
- State: cnt[NTHREADS] (LAT_W+1 bits each) and the L2 table (valid, tag per set).
- On reset, cnt=0 and all valid bits=0.
- Outputs at reset: stay_stalled=0, resp_ctrs all 0, busy_vec=0.
- A token is accepted when req.token_valid & run_reg. Let t=req.tid.
- Accepted token with request_valid=1 and cnt[t]==0 (new request):
  - L2 index = request_addr[LINE_BITS+log2(L2_SETS)-1:LINE_BITS]; tag = the bits above the index.
  - hit = valid[idx] & tag match.
  - On a miss, allocate the entry (valid=1, tag written) at the clock edge.
  - Next cnt[t] = (hit ? l2_hit_lat : dram_lat) + (writeback_valid ? wb_penalty : 0).
  - The sum is LAT_W+1 bits and never saturates.
  - stay_stalled=1 this cycle, even if the loaded value is 0.
  - resp_ctrs.l2hit or .l2miss pulses; .writeback pulses when writeback_valid=1.
- Accepted token with request_valid=0:
  - stay_stalled = (cnt[t]!=0).
  - If cnt[t]!=0, cnt[t] decrements by 1.
  - Net effect: the thread stays stalled for exactly N subsequent tokens and is released on token N+1.
- Accepted token with request_valid=1 while cnt[t]!=0 (protocol violation):
  - The request is ignored: no L2 lookup, no allocate, no reload.
  - cnt[t] decrements as for an idle token; stay_stalled=1.
  - resp_ctrs.proto_err pulses.
- Non-accepted cycle (token_valid=0 or run_reg=0):
  - No state change.
  - stay_stalled = token_valid & (cnt[t]!=0).
  - All resp_ctrs pulses are 0.
- Tokens for different tids never interact. Only the presented tid's counter changes in a cycle.
- An L2 allocate and a lookup to the same index in consecutive cycles see the written tag; write-then-read ordering holds at the edge.
- writeback_addr is not installed in the L2; it only adds penalty.
- Reset mid-stall: all counters clear immediately (asynchronous), and stalled threads are released on their next token.
- busy_vec reflects cnt after the edge, i.e. registered.

Decomposition:
- Shared package (libtm_cache):
  - tm_mem_resp_ctrs_t struct.
  - L2 index/tag width constants derived from L2_SETS and LINE_BITS.
  - tm_mem_request_t stays where it is.
- One sub-module, tm_l2_tag_dm: combinational lookup plus clocked allocate.
  - Ports: idx, tag, alloc_en, hit.
  - Asynchronous reset of the valid bits.

Test Plan:
- Reset, then a tid=0 request to 0x1000 (cold) with dram_lat=3, wb_penalty=2, writeback_valid=1:
  - Expect l2miss=1, writeback=1, stay_stalled=1.
  - Next 5 tid0 tokens stay_stalled=1; the 6th gives 0.
  - busy_vec[0] drops after the 5th.
- After a miss on 0x1000, a tid=1 request to 0x1000 with l2_hit_lat=1 -> l2hit=1; stalled for exactly 1 following tid1 token.
- Interleave tid0/tid1 tokens with tid0 busy (cnt=4) and tid1 idle -> tid1 tokens stay_stalled=0; tid0 counter decrements only on tid0 tokens.
- tid0 request while cnt[0]=2 -> proto_err=1, cnt becomes 1, no L2 allocate (a later lookup of that address misses).
- run_reg=0 with token_valid=1 on tid0 (cnt=3) -> stay_stalled=1 and cnt remains 3.
- Async rst pulse mid-stall (cnt[0]=7) -> busy_vec=0 immediately after the edge; the next tid0 token gives stay_stalled=0; a prior L2 hit address now misses.

Source files
------------

// File: rtl/libtm_cache_pkg.sv
// Shared timing-model cache types: clock bundle, L1-to-memory request token,
// responder event pulses, and the default L2 geometry constants.
package libtm_cache;

    localparam int unsigned NTHREADIDMSB  = 1;
    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned PARTID_W      = 4;
    localparam int unsigned L2_SETS_DEF   = 256;
    localparam int unsigned LINE_BITS_DEF = 6;
    localparam int unsigned L2_IDX_W      = $clog2(L2_SETS_DEF);
    localparam int unsigned L2_TAG_W      = ADDR_W - L2_IDX_W - LINE_BITS_DEF;

    typedef struct packed {
        logic clk;
    } iu_clk_type;

    typedef struct packed {
        logic                    token_valid;
        logic [NTHREADIDMSB:0]   tid;
        logic [PARTID_W-1:0]     partitionid;
        logic                    request_valid;
        logic [ADDR_W-1:0]       request_addr;
        logic                    writeback_valid;
        logic [ADDR_W-1:0]       writeback_addr;
    } tm_mem_request_t;

    typedef struct packed {
        logic l2hit;
        logic l2miss;
        logic writeback;
        logic proto_err;
    } tm_mem_resp_ctrs_t;

    // Classification of the token presented in the current cycle.
    typedef enum logic [1:0] {
        TOK_NONE,
        TOK_IDLE,
        TOK_NEW,
        TOK_PROTO
    } tm_tok_kind_e;

endpackage

// File: rtl/tm_l2_tag_dm.sv
// Direct-mapped L2 tag table: combinational hit lookup, allocate on the clock
// edge so a lookup in the following cycle sees the freshly written tag.
module tm_l2_tag_dm #(
    parameter int unsigned SETS  = 256,
    parameter int unsigned IDX_W = 8,
    parameter int unsigned TAG_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] idx,
    input  logic [TAG_W-1:0] tag,
    input  logic             alloc_en,
    output logic             hit
);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q [SETS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (alloc_en) begin
            valid_q[idx] <= 1'b1;
        end
    end

    // Tag storage is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (alloc_en) begin
            tag_q[idx] <= tag;
        end
    end

    always_comb begin
        hit = valid_q[idx] & (tag_q[idx] == tag);
    end

endmodule

// File: rtl/tm_mem_latency_responder.sv
// Memory-side responder for timing tokens: per-thread latency countdowns,
// L2 hit/miss modelled by a direct-mapped tag table, same-cycle stall reply.
module tm_mem_latency_responder
    import libtm_cache::*;
#(
    parameter int unsigned NTHREADS  = 2**(NTHREADIDMSB+1),
    parameter int unsigned LAT_W     = 8,
    parameter int unsigned L2_SETS   = L2_SETS_DEF,
    parameter int unsigned LINE_BITS = LINE_BITS_DEF
) (
    input  iu_clk_type          gclk,
    input  logic                rst,
    input  logic                run_reg,
    input  tm_mem_request_t     req,
    input  logic [LAT_W-1:0]    l2_hit_lat,
    input  logic [LAT_W-1:0]    dram_lat,
    input  logic [LAT_W-1:0]    wb_penalty,
    output logic                stay_stalled,
    output tm_mem_resp_ctrs_t   resp_ctrs,
    output logic [NTHREADS-1:0] busy_vec
);

    localparam int unsigned CNT_W = LAT_W + 1;
    localparam int unsigned IDX_W = $clog2(L2_SETS);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - LINE_BITS;

    typedef logic [CNT_W-1:0] cnt_t;

    logic [NTHREADS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NTHREADS-1:0]            busy_vec_q, busy_vec_d;

    logic             tok_seen;
    logic             accept;
    logic [NTHREADIDMSB:0] tid;
    cnt_t             cur_cnt;
    logic             cur_busy;
    tm_tok_kind_e     kind;
    logic [IDX_W-1:0] l2_idx;
    logic [TAG_W-1:0] l2_tag;
    logic             l2_hit;
    logic             l2_alloc;
    cnt_t             load_cnt;
    logic             unused_req_bits;

    // Tokens are ignored while reset is held so the outputs stay quiet.
    assign tok_seen = req.token_valid & ~rst;
    assign accept   = tok_seen & run_reg;
    assign tid      = req.tid;
    assign cur_cnt  = cnt_q[tid];
    assign cur_busy = |cur_cnt;

    assign l2_idx   = req.request_addr[LINE_BITS +: IDX_W];
    assign l2_tag   = req.request_addr[LINE_BITS + IDX_W +: TAG_W];

    assign unused_req_bits = ^{req.partitionid, req.writeback_addr,
                               req.request_addr[LINE_BITS-1:0]};

    always_comb begin
        kind = TOK_NONE;
        if (accept) begin
            if (!req.request_valid) begin
                kind = TOK_IDLE;
            end else if (cur_busy) begin
                kind = TOK_PROTO;
            end else begin
                kind = TOK_NEW;
            end
        end
    end

    tm_l2_tag_dm #(
        .SETS  (L2_SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_l2_tags (
        .clk      (gclk.clk),
        .rst      (rst),
        .idx      (l2_idx),
        .tag      (l2_tag),
        .alloc_en (l2_alloc),
        .hit      (l2_hit)
    );

    assign l2_alloc = (kind == TOK_NEW) & ~l2_hit;

    // Latency sum is one bit wider than the config fields and never saturates.
    always_comb begin
        load_cnt = l2_hit ? cnt_t'(l2_hit_lat) : cnt_t'(dram_lat);
        if (req.writeback_valid) begin
            load_cnt = load_cnt + cnt_t'(wb_penalty);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case (kind)
            TOK_NEW: begin
                cnt_d[tid] = load_cnt;
            end
            TOK_IDLE, TOK_PROTO: begin
                if (cur_busy) begin
                    cnt_d[tid] = cur_cnt - cnt_t'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        busy_vec_d = '0;
        for (int unsigned t = 0; t < NTHREADS; t++) begin
            busy_vec_d[t] = |cnt_d[t];
        end
    end

    always_ff @(posedge gclk.clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            busy_vec_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            busy_vec_q <= busy_vec_d;
        end
    end

    always_comb begin
        stay_stalled        = (kind == TOK_NEW) | (tok_seen & cur_busy);
        resp_ctrs           = '0;
        resp_ctrs.l2hit     = (kind == TOK_NEW) & l2_hit;
        resp_ctrs.l2miss    = (kind == TOK_NEW) & ~l2_hit;
        resp_ctrs.writeback = (kind == TOK_NEW) & req.writeback_valid;
        resp_ctrs.proto_err = (kind == TOK_PROTO);
    end

    assign busy_vec = busy_vec_q;

endmodule
